// File: rtl/cpu_defines.sv
// Shared opcode, funct3 and memory-stage state definitions for the my_cpu pipeline.
package cpu_defines;

  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  // size is funct3[1:0]: 00 byte, 01 halfword, 10 word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a load word and sign- or zero-extends it.
module load_align
  import cpu_defines::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      INST_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      INST_LH:  o_data = {{16{w_half[15]}}, w_half};
      INST_LBU: o_data = {24'h0, w_byte};
      INST_LHU: o_data = {16'h0, w_half};
      default:  o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: pass-through of ALU bundles, single-outstanding load/store
// transactions on the data-memory port, and a registered writeback bundle.
module mem_stage
  import cpu_defines::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        rd_en_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_rd_en_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic [31:0] wb_pc_o,
  output logic [31:0] wb_inst_o,
  output logic        misalign_o
);

  mem_state_e r_state, w_state_next;

  logic        r_kill;
  logic        r_dmem_we;
  logic [31:0] r_eff_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_be;
  logic [2:0]  r_funct3;
  logic        r_rd_en;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_pc;
  logic [31:0] r_inst;

  logic        r_wb_valid;
  logic        r_wb_rd_en;
  logic [4:0]  r_wb_rd_addr;
  logic [31:0] r_wb_data;
  logic [31:0] r_wb_pc;
  logic [31:0] r_wb_inst;
  logic        r_misalign;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_accept;
  logic        w_start;
  logic        w_ack;
  logic        w_killed;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_opcode   = inst_i[6:0];
  assign w_funct3   = inst_i[14:12];
  assign w_is_load  = (w_opcode == INST_TYPE_L);
  assign w_is_store = (w_opcode == INST_TYPE_S);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_misalign = w_is_mem & is_misaligned(w_funct3[1:0], alu_result_i[1:0]);
  assign w_accept   = in_valid & in_ready & ~flush_i;
  assign w_start    = w_accept & w_is_mem & ~w_misalign;
  assign w_ack      = (r_state == MEM_ACCESS) & dmem_ack_i;
  // A flush arriving on the ack cycle itself still kills the result.
  assign w_killed   = r_kill | flush_i;

  assign in_ready     = (r_state == MEM_IDLE);
  assign dmem_req_o   = (r_state == MEM_ACCESS);
  assign dmem_we_o    = r_dmem_we;
  assign dmem_addr_o  = {r_eff_addr[31:2], 2'b00};
  assign dmem_wdata_o = r_dmem_wdata;
  assign dmem_be_o    = r_dmem_be;

  assign wb_valid_o   = r_wb_valid;
  assign wb_rd_en_o   = r_wb_rd_en;
  assign wb_rd_addr_o = r_wb_rd_addr;
  assign wb_data_o    = r_wb_data;
  assign wb_pc_o      = r_wb_pc;
  assign wb_inst_o    = r_wb_inst;
  assign misalign_o   = r_misalign;

  always_comb begin
    w_be    = 4'hF;
    w_wdata = store_data_i;
    case (w_funct3)
      INST_SB: begin
        w_be    = 4'b0001 << alu_result_i[1:0];
        w_wdata = {4{store_data_i[7:0]}};
      end
      INST_SH: begin
        w_be    = 4'b0011 << {alu_result_i[1], 1'b0};
        w_wdata = {2{store_data_i[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = store_data_i;
      end
    endcase
  end

  load_align u_load_align (
    .i_rdata   (dmem_rdata_i),
    .i_addr_lo (r_eff_addr[1:0]),
    .i_funct3  (r_funct3),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MEM_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      MEM_IDLE:   if (w_start) w_state_next = MEM_ACCESS;
      MEM_ACCESS: if (dmem_ack_i) w_state_next = MEM_IDLE;
      default:    w_state_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kill       <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_eff_addr   <= 32'h0;
      r_dmem_wdata <= 32'h0;
      r_dmem_be    <= 4'h0;
      r_funct3     <= 3'h0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= 5'h0;
      r_pc         <= 32'h0;
      r_inst       <= 32'h0;
      r_wb_valid   <= 1'b0;
      r_wb_rd_en   <= 1'b0;
      r_wb_rd_addr <= 5'h0;
      r_wb_data    <= 32'h0;
      r_wb_pc      <= 32'h0;
      r_wb_inst    <= 32'h0;
      r_misalign   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;

      if (w_start) begin
        r_dmem_we    <= w_is_store;
        r_eff_addr   <= alu_result_i;
        r_dmem_be    <= w_is_store ? w_be : 4'hF;
        r_dmem_wdata <= w_is_store ? w_wdata : 32'h0;
        r_funct3     <= w_funct3;
        r_rd_en      <= rd_en_i & w_is_load;
        r_rd_addr    <= rd_addr_i;
        r_pc         <= pc_i;
        r_inst       <= inst_i;
      end else if (w_accept) begin
        // Pass-through, or a misaligned access retiring without touching memory.
        r_wb_valid   <= 1'b1;
        r_misalign   <= w_misalign;
        r_wb_rd_en   <= rd_en_i & ~w_misalign;
        r_wb_rd_addr <= rd_addr_i;
        r_wb_data    <= alu_result_i;
        r_wb_pc      <= pc_i;
        r_wb_inst    <= inst_i;
      end

      if (w_ack) begin
        r_kill <= 1'b0;
        if (!w_killed) begin
          r_wb_valid   <= 1'b1;
          r_wb_rd_en   <= r_rd_en;
          r_wb_rd_addr <= r_rd_addr;
          r_wb_data    <= r_dmem_we ? r_eff_addr : w_load_data;
          r_wb_pc      <= r_pc;
          r_wb_inst    <= r_inst;
        end
      end else if ((r_state == MEM_ACCESS) && flush_i) begin
        r_kill <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard-driven bench for mem_stage: expected writebacks are queued at stimulus time.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic        rd_en_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        flush_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic        wb_rd_en_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_pc_o;
  logic [31:0] wb_inst_o;
  logic        misalign_o;

  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_OI = 7'b0010011;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic        mis;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result_i (alu_result_i),
    .store_data_i (store_data_i),
    .rd_en_i      (rd_en_i),
    .rd_addr_i    (rd_addr_i),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .flush_i      (flush_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_rd_en_o   (wb_rd_en_o),
    .wb_rd_addr_o (wb_rd_addr_o),
    .wb_data_o    (wb_data_o),
    .wb_pc_o      (wb_pc_o),
    .wb_inst_o    (wb_inst_o),
    .misalign_o   (misalign_o)
  );

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                       input logic [31:0] sd, input logic [4:0] rd, input logic rden,
                       input logic [31:0] pc);
    in_valid     = 1'b1;
    alu_result_i = res;
    store_data_i = sd;
    rd_en_i      = rden;
    rd_addr_i    = rd;
    pc_i         = pc;
    inst_i       = {17'h0, f3, rd, op};
  endtask

  task automatic push(input logic [31:0] d, input logic cd, input logic re, input logic [4:0] rd,
                      input logic mis, input logic [31:0] pc);
    exp_t x;
    x.data = d; x.chk_data = cd; x.rd_en = re; x.rd_addr = rd; x.mis = mis; x.pc = pc;
    q.push_back(x);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; alu_result_i = '0; store_data_i = '0; rd_en_i = 1'b0;
    rd_addr_i = '0; pc_i = '0; inst_i = '0; flush_i = 1'b0; dmem_ack_i = 1'b0;
    dmem_rdata_i = '0;
    @(negedge clk);
    n_checks++;
    if ({dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_dmem: req=%b we=%b be=%h addr=%h wdata=%h, required all 0",
               dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o);
    end
    n_checks++;
    if ({wb_valid_o, wb_rd_en_o, wb_rd_addr_o, wb_data_o, wb_pc_o, wb_inst_o, misalign_o}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_wb: valid=%b rd_en=%b rd=%0d data=%h pc=%h inst=%h mis=%b, required 0",
               wb_valid_o, wb_rd_en_o, wb_rd_addr_o, wb_data_o, wb_pc_o, wb_inst_o, misalign_o);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_pass_back_to_back;
    @(negedge clk);
    drive(OP_OI, 3'b110, 32'h0000_00FF, 32'h0, 5'd5, 1'b1, 32'h100);
    push(32'h0000_00FF, 1'b1, 1'b1, 5'd5, 1'b0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL pass_ready[%0d]: in_ready=%b, required 1", i, in_ready);
      end
      if (i < 2) begin
        n_checks++;
        if (wb_valid_o !== 1'b1 || q.size() == 0) begin
          n_fail++;
          $display("FAIL pass_wb[%0d]: wb_valid=%b queued=%0d, required 1 with entry",
                   i, wb_valid_o, q.size());
        end else begin
          e = q.pop_front();
          n_checks++;
          if (wb_data_o !== e.data || wb_rd_en_o !== e.rd_en || wb_rd_addr_o !== e.rd_addr ||
              misalign_o !== e.mis || wb_pc_o !== e.pc) begin
            n_fail++;
            $display("FAIL pass_bundle[%0d]: data=%h rd_en=%b rd=%0d mis=%b pc=%h, required %h %b %0d %b %h",
                     i, wb_data_o, wb_rd_en_o, wb_rd_addr_o, misalign_o, wb_pc_o,
                     e.data, e.rd_en, e.rd_addr, e.mis, e.pc);
          end
        end
      end else begin
        n_checks++;
        if (wb_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL pass_idle: wb_valid=%b, required 0", wb_valid_o);
        end
      end
      if (i == 0) begin
        drive(OP_OI, 3'b000, 32'h0000_0001, 32'h0, 5'd6, 1'b1, 32'h104);
        push(32'h0000_0001, 1'b1, 1'b1, 5'd6, 1'b0, 32'h104);
      end else begin
        in_valid = 1'b0;
      end
    end
    // Flush in IDLE discards the same-cycle bundle.
    drive(OP_OI, 3'b000, 32'h0000_0077, 32'h0, 5'd4, 1'b1, 32'h108);
    flush_i = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush_i = 1'b0;
    n_checks++;
    if (wb_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: wb_valid=%b, required 0", wb_valid_o);
    end
  endtask

  task automatic test_lb_wait;
    @(negedge clk);
    drive(OP_L, 3'b000, 32'h0000_1003, 32'h0, 5'd7, 1'b1, 32'h200);
    push(32'hFFFF_FF80, 1'b1, 1'b1, 5'd7, 1'b0, 32'h200);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h1000 || dmem_be_o !== 4'hF ||
          dmem_we_o !== 1'b0 || in_ready !== 1'b0 || wb_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL lb_wait[%0d]: req=%b addr=%h be=%h we=%b ready=%b wbv=%b, required 1 1000 f 0 0 0",
                 i, dmem_req_o, dmem_addr_o, dmem_be_o, dmem_we_o, in_ready, wb_valid_o);
      end
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h8000_0000;
    @(negedge clk);
    dmem_ack_i = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || dmem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_done: in_ready=%b req=%b, required 1 0", in_ready, dmem_req_o);
    end
    n_checks++;
    if (wb_valid_o !== 1'b1 || q.size() == 0) begin
      n_fail++;
      $display("FAIL lb_wb: wb_valid=%b queued=%0d, required 1 with entry", wb_valid_o, q.size());
    end else begin
      e = q.pop_front();
      n_checks++;
      if (wb_data_o !== e.data || wb_rd_en_o !== e.rd_en || wb_rd_addr_o !== e.rd_addr ||
          misalign_o !== e.mis || wb_pc_o !== e.pc) begin
        n_fail++;
        $display("FAIL lb_bundle: data=%h rd_en=%b rd=%0d mis=%b pc=%h, required %h %b %0d %b %h",
                 wb_data_o, wb_rd_en_o, wb_rd_addr_o, misalign_o, wb_pc_o,
                 e.data, e.rd_en, e.rd_addr, e.mis, e.pc);
      end
    end
    // Back-to-back: accept in the same cycle as the load writeback.
    drive(OP_OI, 3'b000, 32'h0000_0055, 32'h0, 5'd9, 1'b1, 32'h204);
    push(32'h0000_0055, 1'b1, 1'b1, 5'd9, 1'b0, 32'h204);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (wb_valid_o !== 1'b1 || q.size() == 0) begin
      n_fail++;
      $display("FAIL b2b_wb: wb_valid=%b queued=%0d, required 1 with entry", wb_valid_o, q.size());
    end else begin
      e = q.pop_front();
      n_checks++;
      if (wb_data_o !== e.data || wb_rd_addr_o !== e.rd_addr || wb_pc_o !== e.pc) begin
        n_fail++;
        $display("FAIL b2b_bundle: data=%h rd=%0d pc=%h, required %h %0d %h",
                 wb_data_o, wb_rd_addr_o, wb_pc_o, e.data, e.rd_addr, e.pc);
      end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  f3 [3]  = '{3'b001, 3'b000, 3'b010};
    logic [31:0] ad [3]  = '{32'h2002, 32'h2001, 32'h2004};
    logic [31:0] sd [3]  = '{32'h1234_ABCD, 32'h0000_00EF, 32'hDEAD_BEEF};
    logic [3:0]  be [3]  = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wd [3]  = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'hDEAD_BEEF};
    logic [31:0] wa [3]  = '{32'h2000, 32'h2000, 32'h2004};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(OP_S, f3[i], ad[i], sd[i], 5'd3, 1'b0, 32'h300 + 32'(i * 4));
      push(32'h0, 1'b0, 1'b0, 5'd3, 1'b0, 32'h300 + 32'(i * 4));
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_be_o !== be[i] ||
          dmem_wdata_o !== wd[i] || dmem_addr_o !== wa[i]) begin
        n_fail++;
        $display("FAIL store_req[%0d]: req=%b we=%b be=%b wdata=%h addr=%h, required 1 1 %b %h %h",
                 i, dmem_req_o, dmem_we_o, dmem_be_o, dmem_wdata_o, dmem_addr_o,
                 be[i], wd[i], wa[i]);
      end
      dmem_ack_i = 1'b1;
      @(negedge clk);
      dmem_ack_i = 1'b0;
      n_checks++;
      if (wb_valid_o !== 1'b1 || q.size() == 0) begin
        n_fail++;
        $display("FAIL store_wb[%0d]: wb_valid=%b queued=%0d, required 1 with entry",
                 i, wb_valid_o, q.size());
      end else begin
        e = q.pop_front();
        n_checks++;
        if (wb_rd_en_o !== e.rd_en || misalign_o !== e.mis || wb_pc_o !== e.pc) begin
          n_fail++;
          $display("FAIL store_bundle[%0d]: rd_en=%b mis=%b pc=%h, required %b %b %h",
                   i, wb_rd_en_o, misalign_o, wb_pc_o, e.rd_en, e.mis, e.pc);
        end
      end
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3 [6] = '{3'b001, 3'b101, 3'b100, 3'b000, 3'b010, 3'b001};
    logic [31:0] ad [6] = '{32'h1002, 32'h1002, 32'h1001, 32'h1000, 32'h1004, 32'h1000};
    logic [31:0] rdv[6] = '{32'h8001_1234, 32'h8001_1234, 32'h0000_AB00, 32'h0000_007F,
                            32'hCAFE_F00D, 32'h0000_F00D};
    logic [31:0] ex [6] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_00AB, 32'h0000_007F,
                            32'hCAFE_F00D, 32'hFFFF_F00D};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(OP_L, f3[i], ad[i], 32'h0, 5'(12 + i), 1'b1, 32'h400 + 32'(i * 4));
      push(ex[i], 1'b1, 1'b1, 5'(12 + i), 1'b0, 32'h400 + 32'(i * 4));
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_be_o !== 4'hF) begin
        n_fail++;
        $display("FAIL load_req[%0d]: req=%b we=%b be=%h, required 1 0 f",
                 i, dmem_req_o, dmem_we_o, dmem_be_o);
      end
      dmem_ack_i = 1'b1; dmem_rdata_i = rdv[i];
      @(negedge clk);
      dmem_ack_i = 1'b0;
      n_checks++;
      if (wb_valid_o !== 1'b1 || q.size() == 0) begin
        n_fail++;
        $display("FAIL load_wb[%0d]: wb_valid=%b queued=%0d, required 1 with entry",
                 i, wb_valid_o, q.size());
      end else begin
        e = q.pop_front();
        n_checks++;
        if (wb_data_o !== e.data || wb_rd_en_o !== e.rd_en || wb_rd_addr_o !== e.rd_addr ||
            wb_pc_o !== e.pc) begin
          n_fail++;
          $display("FAIL load_bundle[%0d]: data=%h rd_en=%b rd=%0d pc=%h, required %h %b %0d %h",
                   i, wb_data_o, wb_rd_en_o, wb_rd_addr_o, wb_pc_o,
                   e.data, e.rd_en, e.rd_addr, e.pc);
        end
      end
    end
  endtask

  task automatic test_misaligned;
    logic [6:0]  op [3] = '{OP_L, OP_L, OP_S};
    logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b010};
    logic [31:0] ad [3] = '{32'h3001, 32'h3003, 32'h3002};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(op[i], f3[i], ad[i], 32'h1111_2222, 5'd8, 1'b1, 32'h500 + 32'(i * 4));
      push(32'h0, 1'b0, 1'b0, 5'd8, 1'b1, 32'h500 + 32'(i * 4));
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (dmem_req_o !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mis_noreq[%0d]: req=%b ready=%b, required 0 1", i, dmem_req_o, in_ready);
      end
      n_checks++;
      if (wb_valid_o !== 1'b1 || q.size() == 0) begin
        n_fail++;
        $display("FAIL mis_wb[%0d]: wb_valid=%b queued=%0d, required 1 with entry",
                 i, wb_valid_o, q.size());
      end else begin
        e = q.pop_front();
        n_checks++;
        if (misalign_o !== e.mis || wb_rd_en_o !== e.rd_en || wb_pc_o !== e.pc) begin
          n_fail++;
          $display("FAIL mis_bundle[%0d]: mis=%b rd_en=%b pc=%h, required %b %b %h",
                   i, misalign_o, wb_rd_en_o, wb_pc_o, e.mis, e.rd_en, e.pc);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (misalign_o !== 1'b0 || wb_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_pulse: mis=%b wbv=%b, required 0 0", misalign_o, wb_valid_o);
    end
  endtask

  task automatic test_flush_access;
    @(negedge clk);
    drive(OP_L, 3'b010, 32'h0000_4000, 32'h0, 5'd10, 1'b1, 32'h600);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (dmem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_req: req=%b, required 1", dmem_req_o);
    end
    flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flush_i = 1'b0;
      n_checks++;
      if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h4000 || wb_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_hold[%0d]: req=%b addr=%h wbv=%b, required 1 4000 0",
                 i, dmem_req_o, dmem_addr_o, wb_valid_o);
      end
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || wb_valid_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: ready=%b wbv=%b req=%b, required 1 0 0",
               in_ready, wb_valid_o, dmem_req_o);
    end
    // ack held high into IDLE must be ignored.
    @(negedge clk);
    dmem_ack_i = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || wb_valid_o !== 1'b0 || dmem_req_o !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_ack: ready=%b wbv=%b req=%b queued=%0d, required 1 0 0 0",
               in_ready, wb_valid_o, dmem_req_o, q.size());
    end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    drive(OP_L, 3'b010, 32'h0000_5004, 32'h0, 5'd11, 1'b1, 32'h700);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (dmem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_req: req=%b, required 1", dmem_req_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b0 || in_ready !== 1'b1 ||
        {dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_dmem: req=%b ready=%b we=%b be=%h addr=%h wdata=%h, required 0 1 0s",
               dmem_req_o, in_ready, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o);
    end
    n_checks++;
    if ({wb_valid_o, wb_rd_en_o, wb_rd_addr_o, wb_data_o, wb_pc_o, wb_inst_o, misalign_o}
        !== '0) begin
      n_fail++;
      $display("FAIL rstmid_wb: valid=%b data=%h pc=%h inst=%h, required 0",
               wb_valid_o, wb_data_o, wb_pc_o, wb_inst_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(OP_L, 3'b010, 32'h0000_5008, 32'h0, 5'd11, 1'b1, 32'h704);
    push(32'hCAFE_F00D, 1'b1, 1'b1, 5'd11, 1'b0, 32'h704);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h5008) begin
      n_fail++;
      $display("FAIL rstmid_next_req: req=%b addr=%h, required 1 5008", dmem_req_o, dmem_addr_o);
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_ack_i = 1'b0;
    n_checks++;
    if (wb_valid_o !== 1'b1 || q.size() == 0) begin
      n_fail++;
      $display("FAIL rstmid_wb_next: wb_valid=%b queued=%0d, required 1 with entry",
               wb_valid_o, q.size());
    end else begin
      e = q.pop_front();
      n_checks++;
      if (wb_data_o !== e.data || wb_rd_en_o !== e.rd_en || wb_rd_addr_o !== e.rd_addr) begin
        n_fail++;
        $display("FAIL rstmid_bundle: data=%h rd_en=%b rd=%0d, required %h %b %0d",
                 wb_data_o, wb_rd_en_o, wb_rd_addr_o, e.data, e.rd_en, e.rd_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_back_to_back();
    test_lb_wait();
    test_stores();
    test_loads();
    test_misaligned();
    test_flush_access();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
